// File: rtl/ps2_pkg.sv
// Shared PS/2 receiver definitions: frame geometry, FSM states and the
// odd-parity helper.
package ps2_pkg;

  localparam int FRAME_BITS = 11;

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  // Parity bit that makes data plus parity carry an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~(^data);
  endfunction

endpackage

// File: rtl/ps2_rx_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count. A pop lets a push into a
// full FIFO; a pop on an empty FIFO is ignored even if a push arrives.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_push,
  input  logic [DATA_W-1:0]       i_wr_data,
  input  logic                    i_pop,
  output logic [DATA_W-1:0]       o_rd_data,
  output logic                    o_empty,
  output logic                    o_full,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic [DATA_W-1:0] r_rd_data;

  logic          w_empty;
  logic          w_full;
  logic          w_do_pop;
  logic          w_do_push;
  logic [AW-1:0] w_next_rd_ptr;

  assign w_empty       = (r_count == '0);
  assign w_full        = (r_count == CNT_FULL);
  assign w_do_pop      = i_pop & ~w_empty;
  assign w_do_push     = i_push & (~w_full | w_do_pop);
  assign w_next_rd_ptr = r_rd_ptr + 1'b1;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_rd_data <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= w_next_rd_ptr;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // The head register bypasses memory when the new byte becomes the head.
      if (w_do_push && (w_empty || (w_do_pop && r_count == CNT_ONE)))
        r_rd_data <= i_wr_data;
      else if (w_do_pop && r_count > CNT_ONE)
        r_rd_data <= r_mem[w_next_rd_ptr];
    end
  end

  assign o_rd_data = r_rd_data;
  assign o_empty   = w_empty;
  assign o_full    = w_full;
  assign o_count   = r_count;
  assign o_drop    = i_push & w_full & ~w_do_pop;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronise and deglitch the lines, deframe
// 11-bit frames, buffer good bytes and keep sticky error flags.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                          CLOCK_50,
  input  logic                          RESET_N,
  input  logic                          PS2_KBCLK,
  input  logic                          PS2_KBDAT,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [7:0]                    rd_data,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYC);
  localparam logic [3:0]    PAR_IDX  = 4'(FRAME_BITS - 2);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic [FW-1:0]          r_filt_cnt;
  logic                   r_filt_clk;
  logic                   r_filt_d;
  logic                   w_clk_s;
  logic                   w_dat_s;
  logic                   w_fall;

  assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
  assign w_dat_s = r_dat_sync[SYNC_STAGES-1];
  assign w_fall  = r_filt_d & ~r_filt_clk;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_filt_cnt <= '0;
      r_filt_clk <= 1'b1;
      r_filt_d   <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], PS2_KBCLK};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], PS2_KBDAT};
      r_filt_d   <= r_filt_clk;
      // Only a run of FILTER_LEN samples that disagree with the filtered level flips it.
      if (w_clk_s == r_filt_clk) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FILT_MAX) begin
        r_filt_clk <= w_clk_s;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  state_t        r_state, w_state_next;
  logic [3:0]    r_bit_cnt, w_bit_next;
  logic [7:0]    r_shift, w_shift_next;
  logic          r_par, w_par_next;
  logic          r_stop, w_stop_next;
  logic [TW-1:0] r_to_cnt, w_to_next;
  logic          w_push;
  logic          w_set_ferr;
  logic          w_set_perr;
  logic          w_drop;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par     <= 1'b0;
      r_stop    <= 1'b0;
      r_to_cnt  <= '0;
    end else begin
      r_state   <= w_state_next;
      r_bit_cnt <= w_bit_next;
      r_shift   <= w_shift_next;
      r_par     <= w_par_next;
      r_stop    <= w_stop_next;
      r_to_cnt  <= w_to_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_bit_next   = r_bit_cnt;
    w_shift_next = r_shift;
    w_par_next   = r_par;
    w_stop_next  = r_stop;
    w_to_next    = '0;
    w_push       = 1'b0;
    w_set_ferr   = 1'b0;
    w_set_perr   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fall) begin
          if (!w_dat_s) begin
            w_state_next = RECV;
            w_bit_next   = 4'd1;
          end else begin
            w_set_ferr = 1'b1;
          end
        end
      end
      RECV: begin
        if (w_fall) begin
          if (r_bit_cnt < PAR_IDX) begin
            w_shift_next = {w_dat_s, r_shift[7:1]};
            w_bit_next   = r_bit_cnt + 4'd1;
          end else if (r_bit_cnt == PAR_IDX) begin
            w_par_next = w_dat_s;
            w_bit_next = r_bit_cnt + 4'd1;
          end else begin
            w_stop_next  = w_dat_s;
            w_bit_next   = '0;
            w_state_next = CHECK;
          end
        end else if (r_to_cnt == TO_MAX) begin
          w_to_next    = r_to_cnt;
          w_set_ferr   = 1'b1;
          w_bit_next   = '0;
          w_state_next = IDLE;
        end else begin
          w_to_next = r_to_cnt + 1'b1;
        end
      end
      CHECK: begin
        w_state_next = IDLE;
        if (!r_stop)
          w_set_ferr = 1'b1;
        else if (odd_parity(r_shift) != r_par)
          w_set_perr = 1'b1;
        else
          w_push = 1'b1;
      end
      default: w_state_next = IDLE;
    endcase
  end

  sync_fifo #(
    .DATA_W (8),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLOCK_50),
    .rst_n     (RESET_N),
    .i_push    (w_push),
    .i_wr_data (r_shift),
    .i_pop     (rd_en),
    .o_rd_data (rd_data),
    .o_empty   (empty),
    .o_full    (full),
    .o_count   (count),
    .o_drop    (w_drop)
  );

  logic r_parity_err, r_frame_err, r_overflow;

  // A new error in the same cycle as clr_err survives the clear.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_parity_err <= w_set_perr | (r_parity_err & ~clr_err);
      r_frame_err  <= w_set_ferr | (r_frame_err & ~clr_err);
      r_overflow   <= w_drop | (r_overflow & ~clr_err);
    end
  end

  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo: bit-banged PS/2 frames, a byte
// scoreboard, a vector table and hand sequences for corner cases.
module tb_ps2_rx_fifo;

  localparam int DEPTH = 8;
  localparam int SYNC  = 2;
  localparam int FILT  = 4;
  localparam int TO    = 400;
  localparam int H     = 25;
  localparam int LAT   = SYNC + FILT + 2;

  logic       clk = 1'b0;
  logic       RESET_N, PS2_KBCLK, PS2_KBDAT, rd_en, clr_err;
  logic [7:0] rd_data;
  logic       empty, full, parity_err, frame_err, overflow;
  logic [3:0] count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q [$];

  ps2_rx_fifo #(
    .FIFO_DEPTH  (DEPTH),
    .SYNC_STAGES (SYNC),
    .FILTER_LEN  (FILT),
    .TIMEOUT_CYC (TO)
  ) dut (
    .CLOCK_50   (clk),
    .RESET_N    (RESET_N),
    .PS2_KBCLK  (PS2_KBCLK),
    .PS2_KBDAT  (PS2_KBDAT),
    .rd_en      (rd_en),
    .clr_err    (clr_err),
    .rd_data    (rd_data),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       bad_par;
    logic       stop;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  function automatic logic [10:0] mk(input logic [7:0] d, input logic bad_par, input logic stop);
    logic p;
    p = ~(^d) ^ bad_par;
    return {stop, p, d, 1'b0};
  endfunction

  task automatic ps2_bit(input logic b);
    @(negedge clk);
    PS2_KBDAT = b;
    repeat (H) @(negedge clk);
    PS2_KBCLK = 1'b0;
    repeat (H) @(negedge clk);
    PS2_KBCLK = 1'b1;
  endtask

  task automatic send_bits(input logic [10:0] f, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) ps2_bit(f[i]);
  endtask

  task automatic send_frame(input logic [10:0] f);
    send_bits(f, 0, 10);
    repeat (10) @(negedge clk);
    PS2_KBDAT = 1'b1;
  endtask

  task automatic model_push(input logic [7:0] d);
    if (exp_q.size() < DEPTH) exp_q.push_back(d);
  endtask

  task automatic read_check(input string name);
    check(name, {24'd0, rd_data}, {24'd0, exp_q[0]});
    void'(exp_q.pop_front());
    @(negedge clk) rd_en = 1'b1;
    @(negedge clk) rd_en = 1'b0;
    check({name, "_count"}, {28'd0, count}, exp_q.size());
  endtask

  task automatic pulse_clr();
    @(negedge clk) clr_err = 1'b1;
    @(negedge clk) clr_err = 1'b0;
  endtask

  initial begin
    logic [10:0] f;
    int          n;
    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'hF0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h1C, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'h32, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'hAA, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0};

    RESET_N = 1'b0; PS2_KBCLK = 1'b1; PS2_KBDAT = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_empty", {31'd0, empty}, 1);
    check("rst_count", {28'd0, count}, 0);
    check("rst_flags", {29'd0, parity_err, frame_err, overflow}, 0);
    RESET_N = 1'b1;
    repeat (5) @(negedge clk);

    // First frame 0x1C with first-byte latency measured from the stop-bit fall.
    f = mk(8'h1C, 1'b0, 1'b1);
    send_bits(f, 0, 9);
    @(negedge clk) PS2_KBDAT = f[10];
    repeat (H) @(negedge clk);
    PS2_KBCLK = 1'b0;
    n = 0;
    while (empty && n < 40) begin
      @(posedge clk); #1; n++;
    end
    check("first_latency", n, LAT);
    repeat (H) @(negedge clk);
    PS2_KBCLK = 1'b1;
    model_push(8'h1C);
    check("first_count", {28'd0, count}, 1);
    read_check("first_rd");
    check("first_empty", {31'd0, empty}, 1);
    check("first_flags", {29'd0, parity_err, frame_err, overflow}, 0);

    // Back-to-back frames.
    send_frame(mk(8'hF0, 1'b0, 1'b1)); model_push(8'hF0);
    send_frame(mk(8'h1C, 1'b0, 1'b1)); model_push(8'h1C);
    check("b2b_count", {28'd0, count}, 2);
    read_check("b2b_rd0");
    read_check("b2b_rd1");
    check("b2b_flags", {29'd0, parity_err, frame_err, overflow}, 0);

    // Vector table.
    foreach (vecs[i]) begin
      send_frame(mk(vecs[i].data, vecs[i].bad_par, vecs[i].stop));
      if (!vecs[i].exp_perr && !vecs[i].exp_ferr) model_push(vecs[i].data);
      check($sformatf("vec%0d_perr", i), {31'd0, parity_err}, {31'd0, vecs[i].exp_perr});
      check($sformatf("vec%0d_ferr", i), {31'd0, frame_err}, {31'd0, vecs[i].exp_ferr});
      check($sformatf("vec%0d_empty", i), {31'd0, empty}, (exp_q.size() == 0) ? 1 : 0);
      while (exp_q.size() > 0) read_check($sformatf("vec%0d_rd", i));
      pulse_clr();
      check($sformatf("vec%0d_clr", i), {30'd0, parity_err, frame_err}, 0);
    end

    // Fill past capacity.
    for (int b = 1; b <= 9; b++) begin
      send_frame(mk(8'(b), 1'b0, 1'b1));
      model_push(8'(b));
    end
    check("fill_full", {31'd0, full}, 1);
    check("fill_count", {28'd0, count}, DEPTH);
    check("fill_ovf", {31'd0, overflow}, 1);
    check("fill_head", {24'd0, rd_data}, 8'h01);

    // Pop in the same cycle the 0x0A push lands while full.
    f = mk(8'h0A, 1'b0, 1'b1);
    send_bits(f, 0, 9);
    @(negedge clk) PS2_KBDAT = f[10];
    repeat (H) @(negedge clk);
    PS2_KBCLK = 1'b0;
    repeat (LAT - 1) @(posedge clk);
    @(negedge clk) rd_en = 1'b1;
    @(negedge clk) rd_en = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(8'h0A);
    repeat (H) @(negedge clk);
    PS2_KBCLK = 1'b1;
    check("poppush_count", {28'd0, count}, DEPTH);
    check("popush_full", {31'd0, full}, 1);
    while (exp_q.size() > 0) read_check("drain_rd");
    check("drain_empty", {31'd0, empty}, 1);
    pulse_clr();
    check("drain_ovf_clr", {31'd0, overflow}, 0);

    // Mid-frame timeout.
    f = mk(8'h55, 1'b0, 1'b1);
    send_bits(f, 0, 4);
    repeat (TO / 2 - H) @(negedge clk);
    check("to_early", {31'd0, frame_err}, 0);
    repeat (TO) @(negedge clk);
    check("to_ferr", {31'd0, frame_err}, 1);
    pulse_clr();
    send_frame(mk(8'h1C, 1'b0, 1'b1)); model_push(8'h1C);
    check("to_next_flags", {29'd0, parity_err, frame_err, overflow}, 0);
    read_check("to_next_rd");

    // Short glitch on the clock line while mid-frame.
    f = mk(8'h1C, 1'b0, 1'b1);
    send_bits(f, 0, 2);
    repeat (5) @(negedge clk);
    PS2_KBCLK = 1'b0;
    repeat (2) @(negedge clk);
    PS2_KBCLK = 1'b1;
    send_bits(f, 3, 10);
    repeat (10) @(negedge clk);
    model_push(8'h1C);
    check("glitch_flags", {29'd0, parity_err, frame_err, overflow}, 0);
    check("glitch_count", {28'd0, count}, 1);
    check("glitch_rd", {24'd0, rd_data}, 8'h1C);

    // Idle falling edge with data high, then reset mid-frame.
    ps2_bit(1'b1);
    repeat (10) @(negedge clk);
    check("idle_ferr", {31'd0, frame_err}, 1);
    ps2_bit(1'b0); ps2_bit(1'b0); ps2_bit(1'b1);
    @(negedge clk) RESET_N = 1'b0;
    #1;
    check("mrst_empty", {31'd0, empty}, 1);
    check("mrst_count", {28'd0, count}, 0);
    check("mrst_rd", {24'd0, rd_data}, 0);
    check("mrst_flags", {29'd0, parity_err, frame_err, overflow}, 0);
    exp_q.delete();
    PS2_KBDAT = 1'b1;
    repeat (3) @(negedge clk);
    RESET_N = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(mk(8'h1C, 1'b0, 1'b1)); model_push(8'h1C);
    check("post_rst_flags", {29'd0, parity_err, frame_err, overflow}, 0);
    check("post_rst_count", {28'd0, count}, 1);
    read_check("post_rst_rd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
